// File: rtl/muldiv_unit.sv
// Multi-cycle radix-2 multiply/divide unit with HI/LO result registers.
// Operands are latched as magnitudes; the sign is fixed up in one extra cycle after the iterations.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x, input logic n);
        return n ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

    function automatic logic [W2-1:0] cneg_d(input logic [W2-1:0] x, input logic n);
        return n ? (~x + {{(W2-1){1'b0}}, 1'b1}) : x;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [W2-1:0]    acc_r;
    logic [WIDTH-1:0] dvsr_r;
    logic             op_div_r, res_neg_r, rem_neg_r;
    logic             accept_s, dz_start_s, signed_s, last_iter_s;
    logic             busy_s, done_s, dz_s;
    logic [WIDTH-1:0] mag1_s, mag2_s;
    logic [WIDTH:0]   mul_sum_s, div_shift_s;
    logic [WIDTH-1:0] div_diff_s;
    logic             div_ge_s;
    logic [W2-1:0]    mul_next_s, div_next_s;

    assign accept_s    = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign dz_start_s  = accept_s && op_i[1] && (src2_i == {WIDTH{1'b0}});
    assign signed_s    = ~op_i[0];
    assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));
    assign mag1_s      = cneg_w(src1_i, signed_s & src1_i[WIDTH-1]);
    assign mag2_s      = cneg_w(src2_i, signed_s & src2_i[WIDTH-1]);

    // Multiply: conditional add into the upper half, then shift the accumulator right.
    assign mul_sum_s  = {1'b0, acc_r[W2-1:WIDTH]} + {1'b0, dvsr_r & {WIDTH{acc_r[0]}}};
    assign mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

    // Divide: shift the next dividend bit into the remainder and try to subtract.
    assign div_shift_s = {acc_r[W2-1:WIDTH], acc_r[WIDTH-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, dvsr_r});
    assign div_diff_s  = div_shift_s[WIDTH-1:0] - dvsr_r;
    assign div_next_s  = {(div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0]),
                          acc_r[WIDTH-2:0], div_ge_s};

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a zero divisor bypasses the iterations entirely.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_s = dz_start_s ? ST_DONE : ST_CALC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_iter_s) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIX:  state_s = ST_DONE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flags come straight from flops.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        dz_s   = 1'b0;
        case (state_s)
            ST_CALC, ST_FIX: busy_s = 1'b1;
            ST_DONE: begin
                done_s = 1'b1;
                dz_s   = dz_start_s;
            end
            default: busy_s = 1'b0;
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            div_zero_o <= 1'b0;
        end else begin
            busy_o     <= busy_s;
            done_o     <= done_s;
            div_zero_o <= dz_s;
        end
    end

    // Datapath: operand capture, iteration, sign fix-up and HI/LO write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {W2{1'b0}};
            dvsr_r    <= {WIDTH{1'b0}};
            op_div_r  <= 1'b0;
            res_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
            hi_o      <= {WIDTH{1'b0}};
            lo_o      <= {WIDTH{1'b0}};
        end else if (dz_start_s) begin
            hi_o <= src1_i;
            lo_o <= {WIDTH{1'b1}};
        end else if (accept_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            op_div_r  <= op_i[1];
            res_neg_r <= signed_s & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
            rem_neg_r <= signed_s & src1_i[WIDTH-1];
            dvsr_r    <= op_i[1] ? mag2_s : mag1_s;
            acc_r     <= {{WIDTH{1'b0}}, (op_i[1] ? mag1_s : mag2_s)};
        end else if (state_r == ST_CALC) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            acc_r <= op_div_r ? div_next_s : mul_next_s;
        end else if (state_r == ST_FIX) begin
            if (op_div_r) begin
                hi_o <= cneg_w(acc_r[W2-1:WIDTH], rem_neg_r);
                lo_o <= cneg_w(acc_r[WIDTH-1:0], res_neg_r);
            end else begin
                {hi_o, lo_o} <= cneg_d(acc_r, res_neg_r);
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised bench for muldiv_unit: stimulus pushes expected results, a monitor pops them on done_o.
module tb_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [31:0] src1_i = 32'd0;
    logic [31:0] src2_i = 32'd0;
    logic        busy_o, done_o, div_zero_o;
    logic [31:0] hi_o, lo_o;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        longint      due;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     errors = 0;
    int     checks = 0;
    int     n_done = 0;
    longint cyc = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .src1_i(src1_i), .src2_i(src2_i), .busy_o(busy_o), .done_o(done_o),
        .div_zero_o(div_zero_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model in plain arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb_v, p, q, r;
        logic [63:0] up;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        e.dz = 1'b0;
        e.due = 0;
        case (op)
            2'd0: begin
                p = sa * sb_v;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'd1: begin
                up = {32'd0, a} * {32'd0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                end else if (op == 2'd2) begin
                    q = sa / sb_v;
                    r = sa % sb_v;
                    e.hi = r[31:0];
                    e.lo = q[31:0];
                end else begin
                    e.hi = a % b;
                    e.lo = a / b;
                end
            end
        endcase
        return e;
    endfunction

    // Called just after a falling edge while the unit is idle or in its done cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(op, a, b);
        e.due = cyc + 1 + (e.dz ? 0 : 33);
        sb.push_back(e);
        op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        op_i    = 2'($urandom_range(0, 3));
        src1_i  = $urandom;
        src2_i  = $urandom;
    endtask

    task automatic wait_done(output int bc);
        bc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (busy_o) bc++;
            if (done_o) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done_o in 100 cycles, expected one");
    endtask

    task automatic directed(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo);
        int bc;
        issue(op, a, b);
        wait_done(bc);
        check("busy_cycles", 64'(bc), (op[1] && b == 32'd0) ? 64'd0 : 64'd33);
        check("hi_const", {32'd0, hi_o}, {32'd0, ehi});
        check("lo_const", {32'd0, lo_o}, {32'd0, elo});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done_o pulse must match the oldest outstanding request.
    always @(negedge clk_i) begin
        if (rst_i && done_o) begin
            n_done++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1, expected no pending request");
            end else begin
                mon_e = sb.pop_front();
                check("hi", {32'd0, hi_o}, {32'd0, mon_e.hi});
                check("lo", {32'd0, lo_o}, {32'd0, mon_e.lo});
                check("div_zero", {63'd0, div_zero_o}, {63'd0, mon_e.dz});
                check("latency", cyc, mon_e.due);
            end
        end
    end

    initial begin
        int bc;
        int nd;
        logic [31:0] a, b;

        repeat (3) @(negedge clk_i);
        check("rst_hi", {32'd0, hi_o}, 64'd0);
        check("rst_lo", {32'd0, lo_o}, 64'd0);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_dz", {63'd0, div_zero_o}, 64'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        directed(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
        directed(2'd0, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        directed(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        directed(2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        directed(2'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
        directed(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        directed(2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

        // HI/LO hold while idle.
        repeat (4) @(negedge clk_i);
        check("hold_hi", {32'd0, hi_o}, 64'd1);
        check("hold_lo", {32'd0, lo_o}, 64'hFFFF_FFFD);

        // A start pulse during CALC must be dropped.
        issue(2'd1, 32'd5, 32'd6);
        repeat (5) @(negedge clk_i);
        op_i = 2'd0; src1_i = 32'd9; src2_i = 32'd9; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(bc);
        check("ignored_start_lo", {32'd0, lo_o}, 64'd30);

        // Reset in the middle of an operation aborts it silently.
        issue(2'd0, 32'h0001_0003, 32'h0002_0005);
        repeat (10) @(negedge clk_i);
        rst_i = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk_i);
        check("abort_hi", {32'd0, hi_o}, 64'd0);
        check("abort_lo", {32'd0, lo_o}, 64'd0);
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        rst_i = 1'b1;
        nd = n_done;
        repeat (40) @(negedge clk_i);
        check("abort_no_done", 64'(n_done), 64'(nd));
        check("abort_idle_busy", {63'd0, busy_o}, 64'd0);
        check("abort_idle_hi", {32'd0, hi_o}, 64'd0);

        // Random operations, mixing back-to-back issue and idle gaps.
        for (int n = 0; n < 60; n++) begin
            a = pick();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
            issue(2'($urandom_range(0, 3)), a, b);
            wait_done(bc);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk_i);
        end

        repeat (3) @(negedge clk_i);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit; the requester/responder partner to the single-cycle ALU for operations the ALU cannot complete in one cycle.
- Decode/control issues a start request with two 32-bit operands.
- The unit iterates radix-2, one bit per clock, and returns a 64-bit result in HI/LO registers with a done pulse.
- HI/LO feed the writeback mux for mfhi/mflo.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- start_i  input  1  request; sampled only in IDLE or DONE.
- op_i  input  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- src1_i  input  WIDTH  multiplicand or dividend (rs).
- src2_i  input  WIDTH  multiplier or divisor (rt).
- busy_o  output  1  high in CALC and FIX.
- done_o  output  1  one-cycle pulse; HI/LO are valid.
- div_zero_o  output  1  pulses with done_o when a divide had divisor 0.
- hi_o  output  WIDTH  HI register: product[63:32] or remainder.
- lo_o  output  WIDTH  LO register: product[31:0] or quotient.

Behaviour:
- Reset (rst_i=0, async): state=IDLE, counter=0, hi_o=0, lo_o=0, busy_o=0, done_o=0, div_zero_o=0.
  - Reset mid-operation aborts the operation; no done_o is produced.
- States: IDLE, CALC, FIX, DONE. busy_o is registered, not decoded late.
- IDLE/DONE with start_i=1 at edge E0:
  - Latch op_i and operand magnitudes. Take the absolute value for signed ops; record result sign and remainder sign.
  - Counter=0; go to CALC.
  - A start in the DONE cycle is accepted, allowing back-to-back operations.
- Divide with src2_i=0 at E0:
  - Go directly to DONE and skip CALC/FIX.
  - Write hi_o=src1_i and lo_o=32'hFFFF_FFFF at E0.
  - div_zero_o=1 and done_o=1 for that one cycle.
- CALC: one iteration per edge; counter increments; after the 32nd CALC edge (E32), go to FIX.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract; a trial remainder ≥ divisor sets the quotient bit.
- FIX (edge E33):
  - Apply sign correction: two's-complement negate the 64-bit product, quotient, or remainder as recorded.
  - Write hi_o and lo_o; go to DONE.
- DONE: done_o=1 for exactly the cycle after E33, i.e. 33 edges after the start edge.
  - With no new start, return to IDLE at the next edge.
- hi_o/lo_o hold their values between operations; they change only at a FIX edge or a div-by-zero start.
- start_i while busy_o=1 is ignored (not queued). Operands and op_i may change freely after E0.
- Signed divide rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 32'h8000_0000 / 32'hFFFF_FFFF gives lo_o=32'h8000_0000, hi_o=0, with no special state.
- Unsigned ops use full 32-bit magnitudes with no sign correction.

Test Plan:
- Reset then idle: rst_i=0 mid-CALC, release -> hi_o=lo_o=0, busy_o=0, no done_o pulse.
- multu src1=32'hFFFF_FFFF, src2=32'h0000_0002 -> done_o 33 edges after start; hi_o=1, lo_o=32'hFFFF_FFFE; busy_o high exactly 33 cycles.
- mult src1=-7 (32'hFFFF_FFF9), src2=3 -> hi_o=32'hFFFF_FFFF, lo_o=32'hFFFF_FFEB.
- div src1=-7, src2=2 -> lo_o=32'hFFFF_FFFD (-3), hi_o=32'hFFFF_FFFF (-1); divu 100/7 -> lo_o=14, hi_o=2.
- divu src2=0, src1=32'h1234 -> done_o and div_zero_o one edge after start; hi_o=32'h1234, lo_o=32'hFFFF_FFFF.
- Back-to-back and ignored start:
  - start_i pulsed during CALC -> ignored; result matches the first operands.
  - start_i held in the DONE cycle -> second operation begins; its done_o comes 33 edges later.
